mux_arbiter_2x1: RTL and testbench
==================================

# mux_arbiter_2x1

Burst round-robin arbiter that shares the 8-bit 2:1 output mux between two upstream first-word-fall-through FIFOs. It pops words from one FIFO at a time, registers the selected word onto the shared output with a valid flag, and drives the registered mux selector. It holds off whenever the downstream stage reports almost-full, and it keeps per-port grant counters for debug.

## Interface
- BW, 8, data width of FIFO words and output.
- BURST, 4, maximum consecutive words granted to one port while the other port is waiting; legal range 1..15.
- CNT_W, 8, width of the per-port grant counters.

- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- fifo0_empty  in  1  port 0 FIFO empty.
- fifo1_empty  in  1  port 1 FIFO empty.
- fifo0_data  in  BW  port 0 head word, valid while fifo0_empty=0.
- fifo1_data  in  BW  port 1 head word.
- down_almost_full  in  1  downstream cannot accept a word next cycle.
- pop0  out  1  combinational; consumes the port 0 head at this edge.
- pop1  out  1  combinational; consumes the port 1 head.
- selector  out  1  registered; port of the word on data_out.
- data_out  out  BW  registered granted word, 0 when not valid.
- valid_out  out  1  registered; data_out carries a word.
- grant_count0  out  CNT_W  words popped from port 0, wraps modulo 2^CNT_W.
- grant_count1  out  CNT_W  words popped from port 1.
- idle  out  1  combinational; high when both FIFOs are empty and no pop occurs.

## Operation
- State: owner `cur` (0/1) and burst counter `bcnt` (0..BURST). Define ne_i = !fifoi_empty.
- Pops are decided combinationally from registered state and inputs each cycle.
  - reset=1 or down_almost_full=1: no pop; cur and bcnt hold (no reset value change while down_almost_full).
  - Else, if ne_cur and bcnt<BURST: pop cur; bcnt+=1.
  - Else, if ne_other: pop other; cur<=other; bcnt<=1.
  - Else, if ne_cur (burst exhausted, other empty): pop cur; bcnt<=1.
  - Else: no pop; bcnt<=0; cur holds.
- pop0 and pop1 are never high together.
- On an edge where pop_i=1: data_out<=fifoi_data, selector<=i, valid_out<=1, grant_count_i+=1 (wrapping).
- On an edge with no pop: valid_out<=0, data_out<=0, and selector holds its last value.
- Reset values: cur=0, bcnt=0, selector=0, data_out=0, valid_out=0, both counters 0; pop0=pop1=0 while reset=1.
- Reset mid-burst discards the burst. The first grant after reset goes to port 0 if it is non-empty.

## Timing
- Latency: pop at cycle N gives data_out/valid_out at cycle N+1. Sustained throughput is one word per cycle.
- down_almost_full sampled high in cycle N gives no pop in N and valid_out=0 in N+1. The word already in flight (popped in N-1) still appears in N. Downstream absorbs this one-cycle skid via its almost-full margin.
- Port switch costs no bubble: the last word of port 0 at N+1 is followed directly by the first word of port 1 at N+2.
- Both ports continuously non-empty: grant pattern is BURST words port 0, then BURST words port 1, repeating.
- Port that empties mid-burst loses ownership immediately if the other port is non-empty.
- Simultaneous fifo becoming non-empty after idle: the current owner `cur` wins.

## Test plan
- Reset behaviour: assert reset 2 cycles with both FIFOs non-empty -> no pops; data_out=0, valid_out=0, selector=0, counters 0. After release, first pop is pop0.
- Single port: port 1 only, words 0x11..0x16, port 0 empty -> six consecutive pop1 (bursts re-arm). valid_out for 6 cycles starting one cycle later, selector=1, grant_count1=6.
- Fair sharing: BURST=4, both FIFOs hold 8 words (0xA0.. / 0xB0..) -> output A0-A3, B0-B3, A4-A7, B4-B7 with no bubbles; selector toggles accordingly.
- Backpressure: raise down_almost_full during the 3rd word of a port 0 burst for 3 cycles -> no pops for 3 cycles, valid_out low for 3 cycles after the in-flight word. The burst then resumes with the 4th port 0 word before switching.
- Reset mid-operation: assert reset after 2 words of a port 1 burst -> next cycle valid_out=0 and counters=0. After release, port 0 is granted first.
- Counter wrap: CNT_W=4, stream 17 words from port 0 -> grant_count0 reads 1.

Source files
------------

// File: rtl/mux_arbiter_2x1.sv
// mux_arbiter_2x1: burst round-robin arbiter sharing one registered 8-bit
// output between two first-word-fall-through FIFOs.
//
// Handshake: the FIFOs present a head word whenever *_empty is low, and
// pop0/pop1 consume that head at the rising edge where they are high.
// The output side has no ready. valid_out qualifies data_out for exactly one
// cycle. The downstream stage throttles the arbiter through down_almost_full,
// one cycle ahead, and absorbs the single in-flight word with its own margin.
//
// Grant rule: the current owner keeps popping until it has taken BURST words
// while the other port waits, or until it runs dry. A lone non-empty port
// re-arms its burst instead of stalling.
module mux_arbiter_2x1 #(
  parameter int BW    = 8,
  parameter int BURST = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo0_empty,
  input  logic             fifo1_empty,
  input  logic [BW-1:0]    fifo0_data,
  input  logic [BW-1:0]    fifo1_data,
  input  logic             down_almost_full,
  output logic             pop0,
  output logic             pop1,
  output logic             selector,
  output logic [BW-1:0]    data_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] grant_count0,
  output logic [CNT_W-1:0] grant_count1,
  output logic             idle,
  output logic             dbg_owner,
  output logic [3:0]       dbg_bcnt
);

  typedef enum logic {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } owner_t;

  // Legal BURST is 1..15, so four bits always hold the burst counter.
  localparam logic [3:0] BURST_MAX = 4'(BURST);

  owner_t     cur;
  owner_t     cur_n;
  logic [3:0] bcnt;
  logic [3:0] bcnt_n;

  logic ne0;
  logic ne1;
  logic ne_cur;
  logic ne_oth;
  logic pop_cur;
  logic pop_oth;
  owner_t oth;

  assign ne0 = ~fifo0_empty;
  assign ne1 = ~fifo1_empty;

  // Owner and burst-count register; reset discards any burst in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur  <= OWN0;
      bcnt <= 4'd0;
    end else begin
      cur  <= cur_n;
      bcnt <= bcnt_n;
    end
  end

  // Grant decision: pick which port pops this cycle and the next owner state.
  always_comb begin
    cur_n   = cur;
    bcnt_n  = bcnt;
    pop_cur = 1'b0;
    pop_oth = 1'b0;
    oth     = (cur == OWN0) ? OWN1 : OWN0;
    ne_cur  = (cur == OWN1) ? ne1 : ne0;
    ne_oth  = (cur == OWN1) ? ne0 : ne1;
    if (!reset && !down_almost_full) begin
      if (ne_cur && (bcnt < BURST_MAX)) begin
        pop_cur = 1'b1;
        bcnt_n  = bcnt + 4'd1;
      end else if (ne_oth) begin
        // Burst exhausted or owner ran dry: hand over with no bubble.
        pop_oth = 1'b1;
        cur_n   = oth;
        bcnt_n  = 4'd1;
      end else if (ne_cur) begin
        // Nobody else wants the mux, so the owner starts a fresh burst.
        pop_cur = 1'b1;
        bcnt_n  = 4'd1;
      end else begin
        bcnt_n  = 4'd0;
      end
    end
  end

  // Map the owner-relative grant onto the physical pop strobes.
  always_comb begin
    pop0 = 1'b0;
    pop1 = 1'b0;
    if (pop_cur) begin
      pop0 = (cur == OWN0);
      pop1 = (cur == OWN1);
    end else if (pop_oth) begin
      pop0 = (cur == OWN1);
      pop1 = (cur == OWN0);
    end
  end

  // Register the granted word; selector keeps the last port across bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      selector  <= 1'b0;
    end else if (pop0) begin
      data_out  <= fifo0_data;
      valid_out <= 1'b1;
      selector  <= 1'b0;
    end else if (pop1) begin
      data_out  <= fifo1_data;
      valid_out <= 1'b1;
      selector  <= 1'b1;
    end else begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end
  end

  // Per-port grant counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_count0 <= '0;
      grant_count1 <= '0;
    end else begin
      if (pop0) grant_count0 <= grant_count0 + CNT_W'(1);
      if (pop1) grant_count1 <= grant_count1 + CNT_W'(1);
    end
  end

  assign idle      = fifo0_empty & fifo1_empty & ~pop0 & ~pop1;
  assign dbg_owner = cur;
  assign dbg_bcnt  = bcnt;

endmodule

// File: tb/tb_mux_arbiter_2x1.sv
// Bench for mux_arbiter_2x1: FIFO models, directed scenarios with
// hand-computed expected words, and an output monitor draining exp_q.
module tb_mux_arbiter_2x1;

  localparam int BW    = 8;
  localparam int BURST = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             fifo0_empty;
  logic             fifo1_empty;
  logic [BW-1:0]    fifo0_data;
  logic [BW-1:0]    fifo1_data;
  logic             down_almost_full;
  logic             pop0;
  logic             pop1;
  logic             selector;
  logic [BW-1:0]    data_out;
  logic             valid_out;
  logic [CNT_W-1:0] grant_count0;
  logic [CNT_W-1:0] grant_count1;
  logic             idle;
  logic             dbg_owner;
  logic [3:0]       dbg_bcnt;

  mux_arbiter_2x1 #(.BW(BW), .BURST(BURST), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .fifo0_empty(fifo0_empty),
    .fifo1_empty(fifo1_empty),
    .fifo0_data(fifo0_data),
    .fifo1_data(fifo1_data),
    .down_almost_full(down_almost_full),
    .pop0(pop0),
    .pop1(pop1),
    .selector(selector),
    .data_out(data_out),
    .valid_out(valid_out),
    .grant_count0(grant_count0),
    .grant_count1(grant_count1),
    .idle(idle),
    .dbg_owner(dbg_owner),
    .dbg_bcnt(dbg_bcnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];
  logic [8:0]    exp_q[$];
  logic [31:0]   trace;
  logic          pend0;
  logic          pend1;
  int            checks;
  int            errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive_fifo();
    fifo0_empty = (q0.size() == 0);
    fifo1_empty = (q1.size() == 0);
    fifo0_data  = (q0.size() != 0) ? q0[0] : 8'h00;
    fifo1_data  = (q1.size() != 0) ? q1[0] : 8'h00;
  endtask

  // One clock: sample pops just before the edge, consume FIFO heads after it.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      drive_fifo();
      #4;
      pend0 = pop0;
      pend1 = pop1;
      @(negedge clk);
      checks++;
      if ((pend0 && pend1) || (pend0 && q0.size() == 0) || (pend1 && q1.size() == 0)) begin
        errors++;
        $display("FAIL pop_legal actual=%0d%0d required=one_nonempty", pend0, pend1);
      end
      if (pend0 && q0.size() != 0) void'(q0.pop_front());
      if (pend1 && q1.size() != 0) void'(q1.pop_front());
      drive_fifo();
    end
  endtask

  task automatic expect_word(input logic sel, input logic [BW-1:0] d);
    exp_q.push_back({sel, d});
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic check_drained(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Low k bits of trace are the valid_out samples of the last k steps.
  task automatic check_trace(input string name, input int k, input logic [31:0] req);
    logic [31:0] mask;
    mask = (32'd1 << k) - 32'd1;
    check(name, trace & mask, req);
  endtask

  // Scoreboard monitor: every valid output word must match the queue head.
  task automatic monitor();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      #1;
      trace = {trace[30:0], valid_out};
      checks++;
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected actual=%0h required=none", {selector, data_out});
        end else begin
          e = exp_q.pop_front();
          if ({selector, data_out} !== e) begin
            errors++;
            $display("FAIL out_word actual=%0h required=%0h", {selector, data_out}, e);
          end
        end
      end else if (data_out !== 8'h00 || valid_out !== 1'b0) begin
        errors++;
        $display("FAIL out_idle actual=%0h/%0b required=0/0", data_out, valid_out);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    trace = '0;
    pend0 = 1'b0;
    pend1 = 1'b0;
    reset = 1'b1;
    down_almost_full = 1'b0;
    fork
      monitor();
    join_none

    // Reset with both FIFOs non-empty: nothing pops, outputs cleared.
    q0.push_back(8'h01);
    q1.push_back(8'h02);
    step(1);
    check("rst_pop_c1", {30'd0, pend0, pend1}, 32'd0);
    step(1);
    check("rst_pop_c2", {30'd0, pend0, pend1}, 32'd0);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_sel", 32'(selector), 32'h0);
    check("rst_cnt0", 32'(grant_count0), 32'h0);
    check("rst_cnt1", 32'(grant_count1), 32'h0);
    reset = 1'b0;
    expect_word(1'b0, 8'h01);
    expect_word(1'b1, 8'h02);
    step(1);
    check("first_pop", {30'd0, pend0, pend1}, 32'b10);
    step(3);
    check_drained("rst_drain");
    check("rst_cnt0_after", 32'(grant_count0), 32'd1);
    check("rst_cnt1_after", 32'(grant_count1), 32'd1);
    check("idle_empty", 32'(idle), 32'd1);

    // Single port: port 1 only, bursts re-arm with no gaps.
    reset_pulse();
    for (int i = 0; i < 6; i++) begin
      q1.push_back(8'h11 + 8'(i));
      expect_word(1'b1, 8'h11 + 8'(i));
    end
    step(8);
    check_trace("single_trace", 8, 32'b0111_1110);
    check_drained("single_drain");
    check("single_sel", 32'(selector), 32'd1);
    check("single_cnt1", 32'(grant_count1), 32'd6);
    check("single_cnt0", 32'(grant_count0), 32'd0);

    // Fair sharing: four-word bursts alternate with no bubble at the switch.
    reset_pulse();
    for (int i = 0; i < 8; i++) begin
      q0.push_back(8'hA0 + 8'(i));
      q1.push_back(8'hB0 + 8'(i));
    end
    for (int i = 0; i < 4; i++) expect_word(1'b0, 8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) expect_word(1'b1, 8'hB0 + 8'(i));
    for (int i = 4; i < 8; i++) expect_word(1'b0, 8'hA0 + 8'(i));
    for (int i = 4; i < 8; i++) expect_word(1'b1, 8'hB0 + 8'(i));
    step(18);
    check_trace("fair_trace", 18, 32'b0_1111111111111111_0);
    check_drained("fair_drain");
    check("fair_cnt0", 32'(grant_count0), 32'd8);
    check("fair_cnt1", 32'(grant_count1), 32'd8);
    check("fair_sel", 32'(selector), 32'd1);

    // Both ports wake together after idle: the last owner (port 1) wins.
    q0.push_back(8'h5A);
    q1.push_back(8'h5B);
    expect_word(1'b1, 8'h5B);
    expect_word(1'b0, 8'h5A);
    step(4);
    check_drained("wake_drain");

    // Backpressure on the third word of a port 0 burst, held three cycles.
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(8'hC0 + 8'(i));
      expect_word(1'b0, 8'hC0 + 8'(i));
    end
    q1.push_back(8'hD0);
    q1.push_back(8'hD1);
    expect_word(1'b1, 8'hD0);
    expect_word(1'b1, 8'hD1);
    step(3);
    down_almost_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("bp_nopop", {30'd0, pend0, pend1}, 32'd0);
    end
    down_almost_full = 1'b0;
    step(1);
    check("bp_resume_p0", {30'd0, pend0, pend1}, 32'b10);
    step(3);
    check_trace("bp_trace", 10, 32'b0111000111);
    step(1);
    check_drained("bp_drain");

    // Reset after two words of a port 1 burst; port 0 wins afterwards.
    reset_pulse();
    for (int i = 0; i < 6; i++) q1.push_back(8'hE0 + 8'(i));
    expect_word(1'b1, 8'hE0);
    expect_word(1'b1, 8'hE1);
    step(2);
    reset = 1'b1;
    q0.push_back(8'hF0);
    step(1);
    check("mid_rst_nopop", {30'd0, pend0, pend1}, 32'd0);
    check("mid_rst_valid", 32'(valid_out), 32'd0);
    check("mid_rst_cnt1", 32'(grant_count1), 32'd0);
    check("mid_rst_sel", 32'(selector), 32'd0);
    reset = 1'b0;
    expect_word(1'b0, 8'hF0);
    for (int i = 2; i < 6; i++) expect_word(1'b1, 8'hE0 + 8'(i));
    step(1);
    check("mid_rst_first", {30'd0, pend0, pend1}, 32'b10);
    step(6);
    check_drained("mid_rst_drain");
    check("mid_rst_cnt0_end", 32'(grant_count0), 32'd1);
    check("mid_rst_cnt1_end", 32'(grant_count1), 32'd4);

    // Counter wrap: 17 words through a 4-bit counter reads back 1.
    reset_pulse();
    for (int i = 0; i < 17; i++) begin
      q0.push_back(8'h30 + 8'(i));
      expect_word(1'b0, 8'h30 + 8'(i));
    end
    step(19);
    check_trace("wrap_trace", 19, 32'b0_11111111111111111_0);
    check_drained("wrap_drain");
    check("wrap_cnt0", 32'(grant_count0), 32'd1);
    check("wrap_cnt1", 32'(grant_count1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
